// File: rtl/nco_phase_mux_if.sv
// Bundles the nco_phase_mux config bus and its angle req/ack stream.
// The master side is the phase mux; the slave side is the register block plus nco consumer.
interface nco_phase_mux_if #(
    parameter int unsigned ANGLE_W = 32,
    parameter int unsigned CHAN_W  = 2
);
    logic               cfg_we;
    logic               cfg_re;
    logic [5:0]         cfg_adr;
    logic [31:0]        cfg_wdat;
    logic [31:0]        cfg_rdat;

    logic [ANGLE_W-1:0] i_angle_dat;
    logic [CHAN_W-1:0]  i_angle_chan;
    logic               i_angle_req;
    logic               i_angle_ack;

    modport master (
        input  cfg_we, cfg_re, cfg_adr, cfg_wdat, i_angle_ack,
        output cfg_rdat, i_angle_dat, i_angle_chan, i_angle_req
    );

    modport slave (
        output cfg_we, cfg_re, cfg_adr, cfg_wdat, i_angle_ack,
        input  cfg_rdat, i_angle_dat, i_angle_chan, i_angle_req
    );
endinterface

// File: rtl/nco_phase_mux.sv
// Time-multiplexed per-channel phase accumulators feeding one CORDIC nco angle input.
// Optional NCO_DITHER_EN adds LFSR dither below the emitted angle LSB.
module nco_phase_mux #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned PHASE_W  = 32,
    parameter int unsigned ANGLE_W  = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    nco_phase_mux_if.master bus
);
    localparam int unsigned CW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned FRAC_W = PHASE_W - ANGLE_W;
    localparam logic [5:0]  ADR_CTRL = 6'd0;

    typedef logic [PHASE_W-1:0] phase_t;

    function automatic phase_t word_to_phase(input logic [31:0] w);
        return PHASE_W'(w);
    endfunction

    function automatic logic [31:0] phase_to_word(input phase_t p);
        return 32'(p);
    endfunction

    function automatic logic [ANGLE_W-1:0] trunc_angle(input phase_t p);
        return ANGLE_W'(p >> FRAC_W);
    endfunction

`ifdef NCO_DITHER_EN
    // Only the bits below the angle LSB receive dither; the mask is empty when FRAC_W is 0.
    function automatic phase_t dither_of(input logic [15:0] l);
        phase_t mask;
        mask = {PHASE_W{1'b1}} >> ANGLE_W;
        return PHASE_W'(l) & mask;
    endfunction
`endif

    logic [CHANNELS-1:0] en_q, en_d;
    phase_t              ftw_q [CHANNELS];
    phase_t              off_q [CHANNELS];
    phase_t              acc_q [CHANNELS];
    logic [CW-1:0]       last_q, last_d;
    logic [ANGLE_W-1:0]  dat_q, dat_d;
    logic [CW-1:0]       chan_q, chan_d;
    logic                req_q, req_d;
    logic [31:0]         rdat_q, rdat_d;

    logic                ctrl_wr;
    logic                pclr;
    logic                adv;
    logic                any_en;
    logic                load;
    logic [CW-1:0]       sel;
    phase_t              acc_sel;
    phase_t              off_sel;
    phase_t              phase_sum;
    logic [31:0]         rd_word;

`ifdef NCO_DITHER_EN
    logic [15:0]         lfsr_q, lfsr_d;
`endif

    assign ctrl_wr = bus.cfg_we && (bus.cfg_adr == ADR_CTRL);
    assign pclr    = ctrl_wr && bus.cfg_wdat[31];
    assign adv     = !req_q || bus.i_angle_ack;
    assign load    = adv && any_en;

    // Round-robin: rotate the enable vector so bit 0 is the channel after the last one emitted.
    always_comb begin
        logic [2*CHANNELS-1:0] en_dup;
        logic [CHANNELS-1:0]   en_rot;
        int                    step;
        int                    idx;
        en_dup = {en_q, en_q};
        en_rot = CHANNELS'(en_dup >> (32'(last_q) + 32'd1));
        step   = 0;
        any_en = 1'b0;
        for (int j = int'(CHANNELS) - 1; j >= 0; j--) begin
            if (en_rot[j]) begin
                any_en = 1'b1;
                step   = j + 1;
            end
        end
        idx = int'(last_q) + step;
        if (idx >= int'(CHANNELS)) begin
            idx = idx - int'(CHANNELS);
        end
        sel = CW'(idx);
    end

    always_comb begin
        acc_sel = '0;
        off_sel = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            if (sel == CW'(c)) begin
                acc_sel = acc_q[c];
                off_sel = off_q[c];
            end
        end
`ifdef NCO_DITHER_EN
        phase_sum = acc_sel + off_sel + dither_of(lfsr_q);
`else
        phase_sum = acc_sel + off_sel;
`endif
    end

    always_comb begin
        rd_word = '0;
        if (bus.cfg_adr == ADR_CTRL) begin
            rd_word = 32'(en_q);
        end
        for (int c = 0; c < int'(CHANNELS); c++) begin
            if (bus.cfg_adr == 6'(2 * c + 1)) begin
                rd_word = phase_to_word(ftw_q[c]);
            end
            if (bus.cfg_adr == 6'(2 * c + 2)) begin
                rd_word = phase_to_word(off_q[c]);
            end
        end
    end

    // Output holding stage: load, drop to idle, or hold under backpressure.
    always_comb begin
        en_d   = ctrl_wr ? bus.cfg_wdat[CHANNELS-1:0] : en_q;
        rdat_d = bus.cfg_re ? rd_word : rdat_q;
        dat_d  = dat_q;
        chan_d = chan_q;
        last_d = last_q;
        req_d  = req_q;
        if (adv) begin
            req_d = any_en;
        end
        if (load) begin
            dat_d  = trunc_angle(phase_sum);
            chan_d = sel;
            last_d = sel;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            en_q   <= '0;
            last_q <= CW'(CHANNELS - 1);
            dat_q  <= '0;
            chan_q <= '0;
            req_q  <= 1'b0;
            rdat_q <= '0;
            for (int c = 0; c < int'(CHANNELS); c++) begin
                ftw_q[c] <= '0;
                off_q[c] <= '0;
                acc_q[c] <= '0;
            end
        end else begin
            en_q   <= en_d;
            last_q <= last_d;
            dat_q  <= dat_d;
            chan_q <= chan_d;
            req_q  <= req_d;
            rdat_q <= rdat_d;
            for (int c = 0; c < int'(CHANNELS); c++) begin
                if (bus.cfg_we && (bus.cfg_adr == 6'(2 * c + 1))) begin
                    ftw_q[c] <= word_to_phase(bus.cfg_wdat);
                end
                if (bus.cfg_we && (bus.cfg_adr == 6'(2 * c + 2))) begin
                    off_q[c] <= word_to_phase(bus.cfg_wdat);
                end
                if (pclr) begin
                    acc_q[c] <= '0;
                end else if (load && (sel == CW'(c))) begin
                    acc_q[c] <= acc_q[c] + ftw_q[c];
                end
            end
        end
    end

`ifdef NCO_DITHER_EN
    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, stepped once per emitted beat.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    assign bus.cfg_rdat     = rdat_q;
    assign bus.i_angle_dat  = dat_q;
    assign bus.i_angle_chan = chan_q;
    assign bus.i_angle_req  = req_q;
endmodule

// File: doc/nco_phase_mux.md
# nco_phase_mux

Multi-channel, time-multiplexed phase-accumulator front-end for the CORDIC `nco` core. It holds per-channel frequency tuning words (FTW) and phase offsets, and round-robins across the enabled channels. Each beat it emits one angle plus channel tag on a req/ack stream that feeds the `nco` angle input directly. It sits between the Wishbone register block, which drives the `cfg_*` port, and the `nco` core. One CORDIC can therefore serve up to `CHANNELS` independent tones without dropping phase.

## Interface
- `CHANNELS`, default 4: number of channels, 1..16.
- `PHASE_W`, default 32: accumulator width, ≥ `ANGLE_W`.
- `ANGLE_W`, default 32: emitted angle width.
- `clk` in 1: clock.
- `reset_n` in 1: synchronous, active-low reset.
- `cfg_we` in 1: config write strobe, one write per cycle.
- `cfg_re` in 1: config read strobe.
- `cfg_adr` in 6: word address.
- `cfg_wdat` in 32: write data.
- `cfg_rdat` out 32: read data, registered.
- `i_angle_dat` out `ANGLE_W`: angle sample.
- `i_angle_chan` out `$clog2(CHANNELS)` (min 1): channel tag of the sample.
- `i_angle_req` out 1: sample valid.
- `i_angle_ack` in 1: downstream accepts.

## Operation
- Register map, with `c` = channel index:
  - 0x00 CTRL: bits `[CHANNELS-1:0]` are per-channel enables. Bit 31 is PCLR, write-1 phase clear; it always reads 0.
  - 0x01+2c FTW[c], `PHASE_W` bits.
  - 0x02+2c OFF[c], `PHASE_W` bits.
  - Writes to unmapped addresses are ignored; reads of them return 0.
  - Fields narrower than 32 bits are zero-extended on read.
- Accumulators `acc[c]` are internal and not readable.
- Output stage is a single holding register. It loads when `!i_angle_req || i_angle_ack` and at least one channel is enabled. On a load:
  - `sel` = next enabled channel after the last emitted channel, wrapping modulo `CHANNELS`. After reset the search starts at channel 0.
  - `i_angle_dat` ← top `ANGLE_W` bits of `(acc[sel] + OFF[sel]) mod 2^PHASE_W`.
  - `i_angle_chan` ← `sel`; `i_angle_req` ← 1.
  - `acc[sel]` ← `acc[sel] + FTW[sel]` mod 2^`PHASE_W`. The emitted sample uses the pre-increment phase.
- If the load condition holds but no channel is enabled, `i_angle_req` ← 0 and `i_angle_dat` / `i_angle_chan` keep their values.
- While `req && !ack`: `i_angle_dat`, `i_angle_chan` and `req` stay stable, and no accumulator moves.
- Channel disabled while its beat is held: the beat is still delivered, and that channel is skipped from then on.
- FTW/OFF write to the channel being loaded in the same cycle: the load uses the old value, and the new value applies from the next load.
- PCLR:
  - All `acc[c]` ← 0 in that cycle. Clear wins over a same-cycle increment.
  - The held output beat is unaffected.
  - The enable bits in the same write are applied.
- Reset (`reset_n`=0 at an edge):
  - Cleared to 0: all FTW, OFF, acc, enables; `i_angle_req`, `i_angle_dat`, `i_angle_chan`, `cfg_rdat`.
  - The round-robin pointer is set so that channel 0 is searched first.
  - Reset overrides a held beat; the beat is dropped.

## Timing
- Config write at edge N; the new value is visible to a load at edge N+1.
- Enable of an idle block written at edge N: `i_angle_req`=1 after edge N+1.
- Read: `cfg_re` at edge N → `cfg_rdat` valid after edge N, held until the next `cfg_re`.
- Throughput: one beat per cycle while `i_angle_ack`=1. Each enabled channel gets exactly one beat per round of K beats, where K = number of enabled channels.
- No combinational path from `i_angle_ack` to any output.

## Configuration
- `NCO_DITHER_EN` defined:
  - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 0xACE1 on reset) advances on every load.
  - Its value, zero-extended or truncated to `PHASE_W-ANGLE_W` bits, is added to `acc+OFF` before truncation.
  - Requires `PHASE_W > ANGLE_W`; otherwise dither is a no-op.
- `NCO_DITHER_EN` undefined: plain truncation; no LFSR logic is present.

## Test plan
- Reset, then CHANNELS=4, PHASE_W=ANGLE_W=32. Write FTW0=0x10000000, CTRL=0x1, ack=1 → dat 0x0, 0x10000000, 0x20000000…; chan=0 every beat.
- Set FTW0=0x1, FTW2=0x100, OFF2=0x80000000, CTRL=0x5, ack=1 → chan sequence 0,2,0,2; dat sequence 0x0, 0x80000000, 0x1, 0x80000100.
- Backpressure: ack=0 for 5 cycles mid-stream → dat and chan frozen; after ack=1 the sequence resumes with no gaps or repeats.
- CTRL=0x8000_0001 written while ack=1 → next beats restart from dat=0x0, then FTW0.
- Write CTRL=0x0 while a beat is held → the held beat is delivered on ack; req=0 the next cycle.
- `reset_n`=0 for one edge mid-stream → req=0, dat=0; a read of FTW0 returns 0.
